// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and the region type used by the VGA timing generator.
package vga_timing_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;

   localparam int H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   localparam int DIV_W = 4;

   typedef enum logic [1:0] {
      REG_ACTIVE,
      REG_FP,
      REG_SYNC,
      REG_BP
   } region_e;

endpackage

// File: rtl/vga_tick_div.sv
// Pixel-rate tick divider: one registered iClk pulse every CLK_DIV cycles.
module vga_tick_div
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic iClk,
   input  logic iRst,
   output logic oPixelTick
);

   if (CLK_DIV < 1 || CLK_DIV > 16) begin : gBadDiv
      $error("vga_tick_div: CLK_DIV must be in 1..16");
   end

   logic [DIV_W-1:0] div_q, div_d;
   logic             tick_q, tick_d;
   logic             divLast;

   assign divLast = (div_q == DIV_W'(CLK_DIV - 1));

   always_comb begin
      div_d  = divLast ? '0 : div_q + 1'b1;
      tick_d = divLast;
   end

   // With CLK_DIV=1 divLast is always true, so the tick holds high after reset.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         div_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         tick_q <= tick_d;
      end
   end

   assign oPixelTick = tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: H/V counters, region FSMs and registered syncs/video-on.
// Define VGA_TIMING_SYNC_PIPE_EN to delay oHSync/oVSync/oVideoOn by one extra iClk.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV  = 2,
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic        iClk,
   input  logic        iRst,
   output logic        oPixelTick,
   output logic        oHSync,
   output logic        oVSync,
   output logic        oVideoOn,
   output logic [15:0] oPixelX,
   output logic [15:0] oPixelY,
   output logic        oFrameStart
);

   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOT >= 65536 || V_TOT >= 65536) begin : gBadTotals
      $error("vga_timing_gen: line/frame totals must be below 65536");
   end

   localparam logic [15:0] H_FP_AT   = 16'(H_ACTIVE);
   localparam logic [15:0] H_SYNC_AT = 16'(H_ACTIVE + H_FP);
   localparam logic [15:0] H_BP_AT   = 16'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [15:0] H_LAST    = 16'(H_TOT - 1);
   localparam logic [15:0] V_FP_AT   = 16'(V_ACTIVE);
   localparam logic [15:0] V_SYNC_AT = 16'(V_ACTIVE + V_FP);
   localparam logic [15:0] V_BP_AT   = 16'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [15:0] V_LAST    = 16'(V_TOT - 1);

   logic        tick;
   logic        lineEnd, frameEnd;
   logic [15:0] xCnt_q, xCnt_d, yCnt_q, yCnt_d;
   region_e     hReg_q, hReg_d, vReg_q, vReg_d;
   logic        hSync_q, hSync_d, vSync_q, vSync_d;
   logic        videoOn_q, videoOn_d, frameStart_q, frameStart_d;

   vga_tick_div #(
      .CLK_DIV(CLK_DIV)
   ) uTickDiv (
      .iClk      (iClk),
      .iRst      (iRst),
      .oPixelTick(tick)
   );

   assign lineEnd  = (xCnt_q == H_LAST);
   assign frameEnd = lineEnd && (yCnt_q == V_LAST);

   // Region and pin values are decoded from the next counter values so that
   // syncs, video-on and X/Y all update on the same iClk edge.
   always_comb begin
      xCnt_d       = xCnt_q;
      yCnt_d       = yCnt_q;
      hReg_d       = hReg_q;
      vReg_d       = vReg_q;
      hSync_d      = hSync_q;
      vSync_d      = vSync_q;
      videoOn_d    = videoOn_q;
      frameStart_d = 1'b0;
      if (tick) begin
         xCnt_d = lineEnd ? '0 : xCnt_q + 16'd1;
         if (lineEnd) begin
            yCnt_d = frameEnd ? '0 : yCnt_q + 16'd1;
         end
         frameStart_d = frameEnd;
         case (hReg_q)
            REG_ACTIVE: if (xCnt_d == H_FP_AT)   hReg_d = REG_FP;
            REG_FP:     if (xCnt_d == H_SYNC_AT) hReg_d = REG_SYNC;
            REG_SYNC:   if (xCnt_d == H_BP_AT)   hReg_d = REG_BP;
            REG_BP:     if (lineEnd)             hReg_d = REG_ACTIVE;
            default:                             hReg_d = REG_ACTIVE;
         endcase
         if (lineEnd) begin
            case (vReg_q)
               REG_ACTIVE: if (yCnt_d == V_FP_AT)   vReg_d = REG_FP;
               REG_FP:     if (yCnt_d == V_SYNC_AT) vReg_d = REG_SYNC;
               REG_SYNC:   if (yCnt_d == V_BP_AT)   vReg_d = REG_BP;
               REG_BP:     if (frameEnd)            vReg_d = REG_ACTIVE;
               default:                             vReg_d = REG_ACTIVE;
            endcase
         end
         hSync_d   = (hReg_d == REG_SYNC) ? SYNC_POL : ~SYNC_POL;
         vSync_d   = (vReg_d == REG_SYNC) ? SYNC_POL : ~SYNC_POL;
         videoOn_d = (hReg_d == REG_ACTIVE) && (vReg_d == REG_ACTIVE);
      end
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         xCnt_q       <= '0;
         yCnt_q       <= '0;
         hReg_q       <= REG_ACTIVE;
         vReg_q       <= REG_ACTIVE;
         hSync_q      <= ~SYNC_POL;
         vSync_q      <= ~SYNC_POL;
         videoOn_q    <= 1'b0;
         frameStart_q <= 1'b0;
      end else begin
         xCnt_q       <= xCnt_d;
         yCnt_q       <= yCnt_d;
         hReg_q       <= hReg_d;
         vReg_q       <= vReg_d;
         hSync_q      <= hSync_d;
         vSync_q      <= vSync_d;
         videoOn_q    <= videoOn_d;
         frameStart_q <= frameStart_d;
      end
   end

`ifdef VGA_TIMING_SYNC_PIPE_EN
   logic hSyncPipe_q, vSyncPipe_q, videoOnPipe_q;

   // Extra stage lines the gating signals up with a colour stage that registers RGB from X/Y.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         hSyncPipe_q   <= ~SYNC_POL;
         vSyncPipe_q   <= ~SYNC_POL;
         videoOnPipe_q <= 1'b0;
      end else begin
         hSyncPipe_q   <= hSync_q;
         vSyncPipe_q   <= vSync_q;
         videoOnPipe_q <= videoOn_q;
      end
   end

   assign oHSync   = hSyncPipe_q;
   assign oVSync   = vSyncPipe_q;
   assign oVideoOn = videoOnPipe_q;
`else
   assign oHSync   = hSync_q;
   assign oVSync   = vSync_q;
   assign oVideoOn = videoOn_q;
`endif

   assign oPixelTick  = tick;
   assign oPixelX     = xCnt_q;
   assign oPixelY     = yCnt_q;
   assign oFrameStart = frameStart_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (640x480 div 2, small raster div 2, 640x480 div 1)
// checked every cycle against an arithmetic raster model, plus directed timing measurements.
module tb_vga_timing_gen;

   logic iClk = 1'b0;
   logic iRst = 1'b1;

   logic [2:0]  tickW, hsW, vsW, vonW, fsW;
   logic [15:0] xW [3];
   logic [15:0] yW [3];

   int total = 0;
   int bad   = 0;

   longint kCyc;

   typedef struct {
      logic   tick, hs, vs, von, fs;
      longint x, y;
   } expT;

   always #5 iClk = ~iClk;

   vga_timing_gen #(.CLK_DIV(2)) dutA (
      .iClk(iClk), .iRst(iRst), .oPixelTick(tickW[0]), .oHSync(hsW[0]), .oVSync(vsW[0]),
      .oVideoOn(vonW[0]), .oPixelX(xW[0]), .oPixelY(yW[0]), .oFrameStart(fsW[0])
   );

   vga_timing_gen #(
      .CLK_DIV(2), .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
      .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
   ) dutB (
      .iClk(iClk), .iRst(iRst), .oPixelTick(tickW[1]), .oHSync(hsW[1]), .oVSync(vsW[1]),
      .oVideoOn(vonW[1]), .oPixelX(xW[1]), .oPixelY(yW[1]), .oFrameStart(fsW[1])
   );

   vga_timing_gen #(.CLK_DIV(1)) dutC (
      .iClk(iClk), .iRst(iRst), .oPixelTick(tickW[2]), .oHSync(hsW[2]), .oVSync(vsW[2]),
      .oVideoOn(vonW[2]), .oPixelX(xW[2]), .oPixelY(yW[2]), .oFrameStart(fsW[2])
   );

   // Model time base: number of iClk edges seen since reset was released.
   always @(posedge iClk or posedge iRst) begin
      if (iRst) kCyc <= 0;
      else      kCyc <= kCyc + 1;
   end

   // Raster expectation after k edges: pixel index p = floor((k-1)/div) ticks consumed.
   function automatic expT model(input int i, input longint k);
      int     d, ha, hf, hsw, hb, va, vf, vsw, vb;
      longint ht, vt, p;
      expT    e;
      if (i == 1) begin
         ha = 20;  hf = 3;  hsw = 5;  hb = 4;  va = 10;  vf = 2;  vsw = 2; vb = 3;
      end else begin
         ha = 640; hf = 16; hsw = 96; hb = 48; va = 480; vf = 10; vsw = 2; vb = 33;
      end
      d  = (i == 2) ? 1 : 2;
      ht = longint'(ha + hf + hsw + hb);
      vt = longint'(va + vf + vsw + vb);
      p  = (k >= 1) ? (k - 1) / d : 0;
      e.x    = p % ht;
      e.y    = (p / ht) % vt;
      e.tick = (k >= 1) && (k % d == 0);
      e.von  = (p >= 1) && (e.x < ha) && (e.y < va);
      e.hs   = !((e.x >= ha + hf) && (e.x < ha + hf + hsw));
      e.vs   = !((e.y >= va + vf) && (e.y < va + vf + vsw));
      e.fs   = (p >= 1) && (p % (ht * vt) == 0) && ((k - 1) % d == 0);
      return e;
   endfunction

   task automatic checkOutput(input string name, input int i, input logic [63:0] act,
                              input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s dut%0d: got %0d, expected %0d at t=%0t", name, i, act, exp, $time);
      end
   endtask

   // Per-cycle compare of every instance against the model.
   always @(negedge iClk) begin
      expT e, ed;
      for (int i = 0; i < 3; i++) begin
         e = model(i, kCyc);
`ifdef VGA_TIMING_SYNC_PIPE_EN
         ed = model(i, (kCyc > 0) ? kCyc - 1 : 0);
`else
         ed = e;
`endif
         checkOutput("tick",  i, 64'(tickW[i]), 64'(e.tick));
         checkOutput("hsync", i, 64'(hsW[i]),   64'(ed.hs));
         checkOutput("vsync", i, 64'(vsW[i]),   64'(ed.vs));
         checkOutput("vidOn", i, 64'(vonW[i]),  64'(ed.von));
         checkOutput("fstart",i, 64'(fsW[i]),   64'(e.fs));
         checkOutput("pixX",  i, 64'(xW[i]),    64'(e.x));
         checkOutput("pixY",  i, 64'(yW[i]),    64'(e.y));
      end
   end

   task automatic checkResetNow();
      for (int i = 0; i < 3; i++) begin
         checkOutput("rstX",    i, 64'(xW[i]),    64'd0);
         checkOutput("rstY",    i, 64'(yW[i]),    64'd0);
         checkOutput("rstTick", i, 64'(tickW[i]), 64'd0);
         checkOutput("rstVid",  i, 64'(vonW[i]),  64'd0);
         checkOutput("rstFs",   i, 64'(fsW[i]),   64'd0);
         checkOutput("rstHs",   i, 64'(hsW[i]),   64'd1);
         checkOutput("rstVs",   i, 64'(vsW[i]),   64'd1);
      end
   endtask

   // Random-length run followed by a reset pulse landing at a random point in the cycle.
   task automatic applyStimulus(input int runCycles, input int holdCycles);
      repeat (runCycles) @(negedge iClk);
      #($urandom_range(1, 3));
      iRst = 1'b1;
      #1;
      checkResetNow();
      repeat (holdCycles) @(posedge iClk);
      @(negedge iClk);
      #1 iRst = 1'b0;
   endtask

   // Ticks (or iClk cycles) between two HSync falling edges, and ticks while HSync is low.
   task automatic measureLine(input int i, input bit byCycles, input int expPeriod,
                              input int expLow, input int expFallX);
      bit prev, found;
      int guard, cnt, low;
      prev = hsW[i]; found = 0; guard = 0;
      while (!found && guard < 5000) begin
         @(negedge iClk);
         guard++;
         if (prev && !hsW[i]) found = 1;
         prev = hsW[i];
      end
      checkOutput("hsFall1Found", i, 64'(found), 64'd1);
      if (!found) return;
      if (expFallX >= 0) checkOutput("hsFallX", i, 64'(xW[i]), 64'(expFallX));
      cnt = byCycles ? 1 : int'(tickW[i]);
      low = int'(tickW[i]);
      found = 0; guard = 0;
      while (!found && guard < 5000) begin
         @(negedge iClk);
         guard++;
         if (prev && !hsW[i]) found = 1;
         else begin
            cnt += byCycles ? 1 : int'(tickW[i]);
            if (!hsW[i]) low += int'(tickW[i]);
         end
         prev = hsW[i];
      end
      checkOutput("hsFall2Found", i, 64'(found), 64'd1);
      checkOutput("linePeriod",   i, 64'(cnt),   64'(expPeriod));
      checkOutput("hsLowTicks",   i, 64'(low),   64'(expLow));
   endtask

   // Small raster: HSync pulses per frame, VSync start line and width, frame-start spacing, corner wrap.
   task automatic measureFrame();
      bit prevV, prevH, found;
      int guard, hsPerFrame, hsInVs, ticks;
      prevV = vsW[1]; prevH = hsW[1]; found = 0; guard = 0;
      while (!found && guard < 3000) begin
         @(negedge iClk);
         guard++;
         if (prevV && !vsW[1]) found = 1;
         prevV = vsW[1]; prevH = hsW[1];
      end
      checkOutput("vsFall1Found", 1, 64'(found), 64'd1);
      checkOutput("vsFallY",      1, 64'(yW[1]), 64'd12);
      hsPerFrame = 0; hsInVs = 0; found = 0; guard = 0;
      while (!found && guard < 3000) begin
         @(negedge iClk);
         guard++;
         if (prevV && !vsW[1]) found = 1;
         else if (prevH && !hsW[1]) begin
            hsPerFrame++;
            if (!vsW[1]) hsInVs++;
         end
         prevV = vsW[1]; prevH = hsW[1];
      end
      checkOutput("vsFall2Found", 1, 64'(found),      64'd1);
      checkOutput("hsPerFrame",   1, 64'(hsPerFrame), 64'd17);
      checkOutput("vsLowLines",   1, 64'(hsInVs),     64'd2);

      found = 0; guard = 0;
      while (!found && guard < 3000) begin
         @(negedge iClk);
         guard++;
         if (fsW[1]) found = 1;
      end
      checkOutput("fs1Found", 1, 64'(found), 64'd1);
      ticks = int'(tickW[1]); found = 0; guard = 0;
      while (!found && guard < 3000) begin
         @(negedge iClk);
         guard++;
         if (fsW[1]) found = 1;
         else ticks += int'(tickW[1]);
      end
      checkOutput("fs2Found",    1, 64'(found), 64'd1);
      checkOutput("frameTicks",  1, 64'(ticks), 64'd544);

      found = 0; guard = 0;
      while (!found && guard < 3000) begin
         @(negedge iClk);
         guard++;
         if (xW[1] == 16'd31 && yW[1] == 16'd16) found = 1;
      end
      checkOutput("cornerFound", 1, 64'(found), 64'd1);
      guard = 0;
      while (xW[1] == 16'd31 && guard < 10) begin
         @(negedge iClk);
         guard++;
      end
      checkOutput("cornerX",  1, 64'(xW[1]),  64'd0);
      checkOutput("cornerY",  1, 64'(yW[1]),  64'd0);
      checkOutput("cornerFs", 1, 64'(fsW[1]), 64'd1);
      @(negedge iClk);
      checkOutput("cornerFsOnce", 1, 64'(fsW[1]), 64'd0);
   endtask

   // Reset in the middle of the small raster, then the first tick after release.
   task automatic midFrameReset();
      bit found;
      int guard;
      found = 0; guard = 0;
      while (!found && guard < 3000) begin
         @(negedge iClk);
         guard++;
         if (xW[1] == 16'd15 && yW[1] == 16'd6) found = 1;
      end
      checkOutput("midFound", 1, 64'(found), 64'd1);
      #2 iRst = 1'b1;
      #1;
      checkResetNow();
      repeat (5) @(posedge iClk);
      @(negedge iClk);
      #1 iRst = 1'b0;
      guard = 0;
      @(negedge iClk);
      while (xW[1] == 16'd0 && guard < 10) begin
         @(negedge iClk);
         guard++;
      end
      checkOutput("relX", 1, 64'(xW[1]), 64'd1);
      checkOutput("relY", 1, 64'(yW[1]), 64'd0);
   endtask

   initial begin
      expT m;
      // Pin the model with hand-computed points.
      m = model(0, 0);
      checkOutput("modelRstVid", 0, 64'(m.von), 64'd0);
      m = model(0, 1313);
      checkOutput("modelX656",   0, 64'(m.x),   64'd656);
      checkOutput("modelHs656",  0, 64'(m.hs),  64'd0);
      m = model(1, 1089);
      checkOutput("modelFsB",    1, 64'(m.fs),  64'd1);
      m = model(2, 801);
      checkOutput("modelXC800",  2, 64'(m.x),   64'd0);
      checkOutput("modelYC800",  2, 64'(m.y),   64'd1);

      iRst = 1'b1;
      repeat (3) @(posedge iClk);
      #1;
      checkResetNow();
      @(negedge iClk);
      #1 iRst = 1'b0;

      $display("[TB] line timing, CLK_DIV=2");
      measureLine(0, 1'b0, 800, 96, 656);
      $display("[TB] line timing, CLK_DIV=1");
      measureLine(2, 1'b1, 800, 96, -1);
      $display("[TB] frame timing on small raster");
      measureFrame();
      $display("[TB] mid-frame reset");
      midFrameReset();

      $display("[TB] random reset pulses");
      for (int n = 0; n < 8; n++) begin
         applyStimulus(int'($urandom_range(20, 2500)), int'($urandom_range(1, 6)));
      end
      repeat (int'($urandom_range(500, 2000))) @(negedge iClk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1500000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
